// File: rtl/video_adapter_pkg.sv
// Shared types and colour expansion for the core-to-Pocket video adapter.
package video_adapter_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb24_t;

  // Wide enough for STABLE_FRAMES up to 15.
  localparam int STAB_W = 4;

  // value holds the channel right-aligned in its low `bits` bits.
  // mode 1 repeats the MSBs into the vacated LSBs; mode 0 leaves them zero.
  function automatic logic [7:0] expand_color(input logic [7:0] value, input int bits,
                                              input logic mode);
    logic [7:0] res;
    logic [2:0] src;
    logic [2:0] dst;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      dst = 3'(7 - i);
      src = 3'(bits - 1 - (i % bits));
      if (mode || (i < bits)) res[dst] = value[src];
    end
    return res;
  endfunction

endpackage

// File: rtl/video_res_meter.sv
// Measures active width/height per frame and flags when they have been stable.
module video_res_meter
  import video_adapter_pkg::*;
#(
  parameter int DIM_BITS      = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                sample_en,
  input  logic                de,
  input  logic                vblank,
  output logic [DIM_BITS-1:0] active_width,
  output logic [DIM_BITS-1:0] active_height,
  output logic                res_valid
);

  localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(STABLE_FRAMES);

  logic                de_q, de_d, vb_q, vb_d;
  logic [DIM_BITS-1:0] pix_q, pix_d, line_w_q, line_w_d, line_cnt_q, line_cnt_d;
  logic [DIM_BITS-1:0] aw_q, aw_d, ah_q, ah_d, line_cnt_lat;
  logic [STAB_W-1:0]   stab_q, stab_d;
  logic                de_fall, vb_rise;

  function automatic logic [DIM_BITS-1:0] sat_inc(input logic [DIM_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    de_fall      = sample_en && de_q && !de;
    vb_rise      = sample_en && !vb_q && vblank;
    de_d         = sample_en ? de : de_q;
    vb_d         = sample_en ? vblank : vb_q;
    pix_d        = pix_q;
    if (sample_en) pix_d = de ? sat_inc(pix_q) : '0;
    line_w_d     = de_fall ? pix_q : line_w_q;
    line_cnt_lat = de_fall ? sat_inc(line_cnt_q) : line_cnt_q;
    line_cnt_d   = line_cnt_lat;
    aw_d         = aw_q;
    ah_d         = ah_q;
    stab_d       = stab_q;
    // A line ending on the same sample as vblank rises is counted in this frame.
    if (vb_rise) begin
      aw_d       = line_w_d;
      ah_d       = line_cnt_lat;
      line_cnt_d = '0;
      if ((line_w_d == aw_q) && (line_cnt_lat == ah_q))
        stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
      else
        stab_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q       <= 1'b0;
      vb_q       <= 1'b1;
      pix_q      <= '0;
      line_w_q   <= '0;
      line_cnt_q <= '0;
      aw_q       <= '0;
      ah_q       <= '0;
      stab_q     <= '0;
    end else begin
      de_q       <= de_d;
      vb_q       <= vb_d;
      pix_q      <= pix_d;
      line_w_q   <= line_w_d;
      line_cnt_q <= line_cnt_d;
      aw_q       <= aw_d;
      ah_q       <= ah_d;
      stab_q     <= stab_d;
    end
  end

  assign active_width  = aw_q;
  assign active_height = ah_q;
  assign res_valid     = (stab_q == STAB_MAX);

endmodule

// File: rtl/core_video_adapter.sv
// Bridges an arcade core's CE-strobed video to the Pocket video signal set,
// with sync edge pulses, colour expansion, CE stretching and resolution metering.
module core_video_adapter
  import video_adapter_pkg::*;
#(
  parameter int COLOR_BITS    = 4,
  parameter int EXPAND_MODE   = 1,
  parameter int SYNC_ACTIVE   = 1,
  parameter int CE_STRETCH    = 2,
  parameter int DIM_BITS      = 12,
  parameter int STABLE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  ce_pixel,
  input  logic                  hblank,
  input  logic                  vblank,
  input  logic                  hsync,
  input  logic                  vsync,
  input  logic [COLOR_BITS-1:0] r,
  input  logic [COLOR_BITS-1:0] g,
  input  logic [COLOR_BITS-1:0] b,
  input  logic                  video_enable,
  output logic                  out_de,
  output logic [23:0]           out_rgb,
  output logic                  out_hs,
  output logic                  out_vs,
  output logic                  out_skip,
  output logic                  out_ce_held,
  output logic [DIM_BITS-1:0]   active_width,
  output logic [DIM_BITS-1:0]   active_height,
  output logic                  res_valid
);

  localparam logic       SYNC_INV     = (SYNC_ACTIVE == 0);
  localparam logic       EXP_REP      = (EXPAND_MODE != 0);
  localparam logic [1:0] STRETCH_LOAD = 2'(CE_STRETCH - 1);

  logic                  hblank_q, hblank_d, vblank_q, vblank_d;
  logic                  hs_q, hs_d, vs_q, vs_d, hs_n, vs_n;
  logic [COLOR_BITS-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic                  hs_pulse_q, hs_pulse_d, vs_pulse_q, vs_pulse_d;
  logic                  held_q, held_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [7:0]            r_ext, g_ext, b_ext;
  rgb24_t                pix;

  always_comb begin
    hs_n       = hsync ^ SYNC_INV;
    vs_n       = vsync ^ SYNC_INV;
    hblank_d   = ce_pixel ? hblank : hblank_q;
    vblank_d   = ce_pixel ? vblank : vblank_q;
    hs_d       = ce_pixel ? hs_n : hs_q;
    vs_d       = ce_pixel ? vs_n : vs_q;
    r_d        = ce_pixel ? r : r_q;
    g_d        = ce_pixel ? g : g_q;
    b_d        = ce_pixel ? b : b_q;
    hs_pulse_d = ce_pixel && hs_n && !hs_q;
    vs_pulse_d = ce_pixel && vs_n && !vs_q;
    // A strobe inside the stretch window reloads, so back-to-back strobes never gap.
    held_d     = ce_pixel || (cnt_q != 2'd0);
    if (ce_pixel)            cnt_d = STRETCH_LOAD;
    else if (cnt_q != 2'd0)  cnt_d = cnt_q - 2'd1;
    else                     cnt_d = cnt_q;
  end

  // Sync history resets to "active" so the first sample after reset cannot pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hblank_q   <= 1'b1;
      vblank_q   <= 1'b1;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      r_q        <= '0;
      g_q        <= '0;
      b_q        <= '0;
      hs_pulse_q <= 1'b0;
      vs_pulse_q <= 1'b0;
      held_q     <= 1'b0;
      cnt_q      <= 2'd0;
    end else begin
      hblank_q   <= hblank_d;
      vblank_q   <= vblank_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      r_q        <= r_d;
      g_q        <= g_d;
      b_q        <= b_d;
      hs_pulse_q <= hs_pulse_d;
      vs_pulse_q <= vs_pulse_d;
      held_q     <= held_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    r_ext = '0;
    g_ext = '0;
    b_ext = '0;
    r_ext[COLOR_BITS-1:0] = r_q;
    g_ext[COLOR_BITS-1:0] = g_q;
    b_ext[COLOR_BITS-1:0] = b_q;
    pix.r = expand_color(r_ext, COLOR_BITS, EXP_REP);
    pix.g = expand_color(g_ext, COLOR_BITS, EXP_REP);
    pix.b = expand_color(b_ext, COLOR_BITS, EXP_REP);
  end

  assign out_de      = !(hblank_q || vblank_q);
  assign out_rgb     = (out_de && video_enable) ? {pix.r, pix.g, pix.b} : 24'h0;
  assign out_hs      = hs_pulse_q;
  assign out_vs      = vs_pulse_q;
  assign out_ce_held = held_q;
  assign out_skip    = out_de && !held_q;

  video_res_meter #(
    .DIM_BITS      (DIM_BITS),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_meter (
    .clk           (clk),
    .reset_n       (reset_n),
    .sample_en     (ce_pixel),
    .de            (!(hblank || vblank)),
    .vblank        (vblank),
    .active_width  (active_width),
    .active_height (active_height),
    .res_valid     (res_valid)
  );

endmodule

// File: tb/tb_core_video_adapter.sv
// Directed bench: default-parameter adapter plus a zero-pad / active-low-sync variant.
module tb_core_video_adapter;

  logic       clk = 1'b0, reset_n = 1'b0, ce_pixel = 1'b0;
  logic       hblank = 1'b1, vblank = 1'b1, hsync = 1'b1, vsync = 1'b1, video_enable = 1'b1;
  logic [3:0] r = '0, g = '0, b = '0;

  logic        a_de, a_hs, a_vs, a_skip, a_held, a_valid;
  logic [23:0] a_rgb;
  logic [11:0] a_w, a_h;
  logic        z_de, z_hs, z_vs, z_skip, z_held, z_valid;
  logic [23:0] z_rgb;
  logic [11:0] z_w, z_h;

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  core_video_adapter dut (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .video_enable(video_enable),
    .out_de(a_de), .out_rgb(a_rgb), .out_hs(a_hs), .out_vs(a_vs), .out_skip(a_skip),
    .out_ce_held(a_held), .active_width(a_w), .active_height(a_h), .res_valid(a_valid)
  );

  core_video_adapter #(.EXPAND_MODE(0), .SYNC_ACTIVE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .ce_pixel(ce_pixel), .hblank(hblank), .vblank(vblank),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b), .video_enable(video_enable),
    .out_de(z_de), .out_rgb(z_rgb), .out_hs(z_hs), .out_vs(z_vs), .out_skip(z_skip),
    .out_ce_held(z_held), .active_width(z_w), .active_height(z_h), .res_valid(z_valid)
  );

  task automatic drive(input logic ce, input logic hb, input logic vb);
    ce_pixel = ce;
    hblank   = hb;
    vblank   = vb;
    @(negedge clk);
  endtask

  task automatic test_reset;
    logic [65:0] a_all, z_all;
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      ce_pixel = 1'($urandom); hblank = 1'($urandom); vblank = 1'($urandom);
      hsync = 1'($urandom); vsync = 1'($urandom); video_enable = 1'($urandom);
      r = 4'($urandom); g = 4'($urandom); b = 4'($urandom);
      @(negedge clk);
      a_all = {a_de, a_rgb, a_hs, a_vs, a_skip, a_held, a_w, a_h, a_valid};
      z_all = {z_de, z_rgb, z_hs, z_vs, z_skip, z_held, z_w, z_h, z_valid};
      total_cnt++;
      if (a_all !== 66'h0) $display("FAIL reset_hold_a got %h exp 0", a_all); else pass_cnt++;
      total_cnt++;
      if (z_all !== 66'h0) $display("FAIL reset_hold_z got %h exp 0", z_all); else pass_cnt++;
    end
    ce_pixel = 1'b0; hblank = 1'b1; vblank = 1'b1; hsync = 1'b1; vsync = 1'b1;
    video_enable = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a_all = {a_de, a_rgb, a_hs, a_vs, a_skip, a_held, a_w, a_h, a_valid};
      total_cnt++;
      if (a_all !== 66'h0) $display("FAIL reset_idle got %h exp 0", a_all); else pass_cnt++;
    end
    drive(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if ({a_hs, a_vs, z_hs, z_vs} !== 4'b0)
      $display("FAIL first_sample_pulse got %b exp 0000", {a_hs, a_vs, z_hs, z_vs});
    else pass_cnt++;
    total_cnt++;
    if (a_held !== 1'b1) $display("FAIL first_ce_held got %b exp 1", a_held); else pass_cnt++;
  endtask

  task automatic test_color;
    r = 4'hA; g = 4'h5; b = 4'hF; video_enable = 1'b1;
    drive(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (a_rgb !== 24'hAA55FF) $display("FAIL rgb_replicate got %h exp AA55FF", a_rgb); else pass_cnt++;
    total_cnt++;
    if (z_rgb !== 24'hA050F0) $display("FAIL rgb_zeropad got %h exp A050F0", z_rgb); else pass_cnt++;
    total_cnt++;
    if (a_de !== 1'b1) $display("FAIL de_active got %b exp 1", a_de); else pass_cnt++;
    video_enable = 1'b0;
    #1;
    total_cnt++;
    if ({a_de, a_rgb} !== {1'b1, 24'h0})
      $display("FAIL video_disable got de=%b rgb=%h exp de=1 rgb=000000", a_de, a_rgb);
    else pass_cnt++;
    video_enable = 1'b1;
    r = 4'h0; g = 4'h0; b = 4'h0;
    drive(1'b0, 1'b1, 1'b1);
    total_cnt++;
    if ({a_de, a_rgb} !== {1'b1, 24'hAA55FF})
      $display("FAIL hold_between_ce got de=%b rgb=%h exp de=1 rgb=AA55FF", a_de, a_rgb);
    else pass_cnt++;
    r = 4'h1; g = 4'h0; b = 4'h8;
    drive(1'b1, 1'b0, 1'b0);
    total_cnt++;
    if (a_rgb !== 24'h110088) $display("FAIL rgb_rep2 got %h exp 110088", a_rgb); else pass_cnt++;
    total_cnt++;
    if (z_rgb !== 24'h100080) $display("FAIL rgb_pad2 got %h exp 100080", z_rgb); else pass_cnt++;
    drive(1'b1, 1'b1, 1'b0);
    total_cnt++;
    if ({a_de, a_rgb} !== 25'h0)
      $display("FAIL hblank_black got de=%b rgb=%h exp de=0 rgb=000000", a_de, a_rgb);
    else pass_cnt++;
  endtask

  task automatic test_ce_stretch;
    logic exp_held;
    for (int i = 0; i < 8; i++) begin
      drive(i % 2 == 0, 1'b0, 1'b0);
      total_cnt++;
      if ({a_held, a_skip} !== 2'b10)
        $display("FAIL ce_div2 i=%0d got held=%b skip=%b exp held=1 skip=0", i, a_held, a_skip);
      else pass_cnt++;
    end
    for (int i = 0; i < 12; i++) begin
      drive(i % 4 == 0, 1'b0, 1'b0);
      exp_held = (i % 4) < 2;
      total_cnt++;
      if ({a_held, a_skip} !== {exp_held, !exp_held})
        $display("FAIL ce_div4 i=%0d got held=%b skip=%b exp held=%b skip=%b",
                 i, a_held, a_skip, exp_held, !exp_held);
      else pass_cnt++;
    end
  endtask

  task automatic test_sync;
    for (int i = 0; i < 40; i++) begin
      hsync = (i >= 7 && i < 27) ? 1'b0 : 1'b1;
      vsync = (i >= 12 && i < 14) ? 1'b0 : 1'b1;
      drive(i % 2 == 0, 1'b0, 1'b0);
      total_cnt++;
      if (z_hs !== (i == 8)) $display("FAIL hs_lowactive i=%0d got %b exp %b", i, z_hs, i == 8);
      else pass_cnt++;
      total_cnt++;
      if (a_hs !== (i == 28)) $display("FAIL hs_highactive i=%0d got %b exp %b", i, a_hs, i == 28);
      else pass_cnt++;
      total_cnt++;
      if (z_vs !== (i == 12)) $display("FAIL vs_lowactive i=%0d got %b exp %b", i, z_vs, i == 12);
      else pass_cnt++;
      total_cnt++;
      if (a_vs !== (i == 14)) $display("FAIL vs_highactive i=%0d got %b exp %b", i, a_vs, i == 14);
      else pass_cnt++;
    end
  endtask

  task automatic frame(input int w, input int h, input bit direct, input int exp_w,
                       input int exp_h, input bit exp_v_before, input bit exp_v_after);
    drive(1'b1, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) drive(1'b1, 1'b0, 1'b0);
      if (!(direct && l == h - 1))
        for (int p = 0; p < 3; p++) drive(1'b1, 1'b1, 1'b0);
    end
    total_cnt++;
    if (a_valid !== exp_v_before)
      $display("FAIL valid_before_latch %0dx%0d got %b exp %b", w, h, a_valid, exp_v_before);
    else pass_cnt++;
    drive(1'b1, 1'b1, 1'b1);
    total_cnt++;
    if ({a_w, a_h} !== {12'(exp_w), 12'(exp_h)})
      $display("FAIL frame_dims %0dx%0d got %0dx%0d exp %0dx%0d", w, h, a_w, a_h, exp_w, exp_h);
    else pass_cnt++;
    total_cnt++;
    if (a_valid !== exp_v_after)
      $display("FAIL valid_at_latch %0dx%0d got %b exp %b", w, h, a_valid, exp_v_after);
    else pass_cnt++;
    repeat (4) drive(1'b1, 1'b1, 1'b1);
  endtask

  task automatic test_meter;
    reset_n = 1'b0; hblank = 1'b1; vblank = 1'b1; hsync = 1'b1; vsync = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) drive(1'b1, 1'b1, 1'b1);
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b0);
    frame(20, 6, 1'b1, 20, 6, 1'b0, 1'b0);
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b1);
    frame(20, 5, 1'b0, 20, 5, 1'b1, 1'b0);
    frame(0, 0, 1'b0, 20, 0, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset;
    logic [65:0] a_all;
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0);
    for (int p = 0; p < 7; p++) drive(1'b1, 1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    a_all = {a_de, a_rgb, a_hs, a_vs, a_skip, a_held, a_w, a_h, a_valid};
    total_cnt++;
    if (a_all !== 66'h0) $display("FAIL async_reset got %h exp 0", a_all); else pass_cnt++;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) drive(1'b1, 1'b1, 1'b1);
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b0);
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b0);
    frame(20, 6, 1'b0, 20, 6, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_color();
    test_ce_stretch();
    test_sync();
    test_meter();
    test_async_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
